ysyx_23060096_issue: RTL and testbench

YSYX_23060096_ISSUE -- requirements
Module: ysyx_23060096_issue

---
 rtl/ysyx_23060096_issue.sv | 166 ++++++++++++++++
 tb/tb_ysyx_23060096_issue.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060096_issue.sv
// In-order single-entry issue stage: decodes register usage, blocks on a busy-bit
// scoreboard (RAW and WAW), reads operands and holds one instruction for execute.
module ysyx_23060096_issue #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  input  logic [XLEN-1:0] busA,
  input  logic [XLEN-1:0] busB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [4:0]      out_rd,
  output logic            out_wen,
  output logic            out_illegal,
  output logic [31:0]     out_inst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [4:0] rs1, rs2, rd;
  logic       uses_rs1, uses_rs2, writes_rd, illegal;

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];
  assign ra  = rs1;
  assign rb  = rs2;

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    illegal   = 1'b0;
    case (in_inst[6:0])
      OP_LUI, OP_AUIPC, OP_JAL: writes_rd = 1'b1;
      OP_JALR, OP_LOAD, OP_IMM: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_BRANCH, OP_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OP_SYSTEM: ;
      default: illegal = 1'b1;
    endcase
  end

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_src1_q, out_src1_d;
  logic [XLEN-1:0] out_src2_q, out_src2_d;
  logic [4:0]      out_rd_q, out_rd_d;
  logic            out_wen_q, out_wen_d;
  logic            out_illegal_q, out_illegal_d;
  logic [31:0]     out_inst_q, out_inst_d;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] rs1_hit, rs2_hit, rd_hit;
  logic            hazard, fire, new_wen, flush_kill;

  assign new_wen    = writes_rd & (rd != 5'd0);
  assign hazard     = (uses_rs1 & (|rs1_hit)) | (uses_rs2 & (|rs2_hit)) | (writes_rd & (|rd_hit));
  assign in_ready   = (~out_valid_q | out_ready) & ~hazard & ~flush;
  assign fire       = in_valid & in_ready;
  // A flushed entry never reaches writeback, so it must release its destination.
  assign flush_kill = flush & out_valid_q & out_wen_q;

  // x0 is never busy, so a zero index cannot produce a hit; set outranks clear.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
    assign rs1_hit[gi] = busy_q[gi] & (rs1 == 5'(gi));
    assign rs2_hit[gi] = busy_q[gi] & (rs2 == 5'(gi));
    assign rd_hit[gi]  = busy_q[gi] & (rd == 5'(gi));
    if (gi == 0) begin : g_zero
      assign busy_d[gi] = 1'b0;
    end else begin : g_reg
      assign busy_d[gi] = (fire & new_wen & (rd == 5'(gi)))
                        | (busy_q[gi] & ~((wb_valid & (wb_rd == 5'(gi)))
                                          | (flush_kill & (out_rd_q == 5'(gi)))));
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_src1_d    = out_src1_q;
    out_src2_d    = out_src2_q;
    out_rd_d      = out_rd_q;
    out_wen_d     = out_wen_q;
    out_illegal_d = out_illegal_q;
    out_inst_d    = out_inst_q;
    if (fire) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_src1_d    = (rs1 == 5'd0) ? '0 : busA;
      out_src2_d    = (rs2 == 5'd0) ? '0 : busB;
      out_rd_d      = rd;
      out_wen_d     = new_wen;
      out_illegal_d = illegal;
      out_inst_d    = in_inst;
    end else if (flush | out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= '0;
      out_src1_q    <= '0;
      out_src2_q    <= '0;
      out_rd_q      <= '0;
      out_wen_q     <= 1'b0;
      out_illegal_q <= 1'b0;
      out_inst_q    <= '0;
      busy_q        <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_src1_q    <= out_src1_d;
      out_src2_q    <= out_src2_d;
      out_rd_q      <= out_rd_d;
      out_wen_q     <= out_wen_d;
      out_illegal_q <= out_illegal_d;
      out_inst_q    <= out_inst_d;
      busy_q        <= busy_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_src1    = out_src1_q;
  assign out_src2    = out_src2_q;
  assign out_rd      = out_rd_q;
  assign out_wen     = out_wen_q;
  assign out_illegal = out_illegal_q;
  assign out_inst    = out_inst_q;

endmodule

// File: tb/tb_ysyx_23060096_issue.sv
// Self-checking bench for ysyx_23060096_issue: decode table, directed hazard/stall/flush
// sequences and a randomized run against a scoreboard-level reference model.
module tb_ysyx_23060096_issue;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  ra, rb;
  logic [31:0] busA, busB;
  logic        out_valid, out_ready;
  logic [31:0] out_pc, out_src1, out_src2, out_inst;
  logic [4:0]  out_rd;
  logic        out_wen, out_illegal;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;

  int checks = 0;
  int errors = 0;

  ysyx_23060096_issue #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .ra(ra), .rb(rb), .busA(busA), .busB(busB),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_src1(out_src1), .out_src2(out_src2), .out_rd(out_rd),
    .out_wen(out_wen), .out_illegal(out_illegal), .out_inst(out_inst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush)
  );

  always #5 clk = ~clk;

  // Reference model: the held instruction plus one busy flag per register.
  bit          mbusy [32];
  bit          m_valid, m_wen, m_ill;
  logic [31:0] m_pc, m_src1, m_src2, m_inst;
  logic [4:0]  m_rd;
  logic        last_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // {uses_rs1, uses_rs2, writes_rd, illegal} by major opcode.
  function automatic logic [3:0] dec(input logic [6:0] op);
    case (op)
      7'h37, 7'h17, 7'h6F: return 4'b0010;
      7'h67, 7'h03, 7'h13: return 4'b1010;
      7'h63, 7'h23:        return 4'b1100;
      7'h33:               return 4'b1110;
      7'h73:               return 4'b0000;
      default:             return 4'b0001;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
    m_valid = 1'b0; m_wen = 1'b0; m_ill = 1'b0;
    m_pc = '0; m_src1 = '0; m_src2 = '0; m_inst = '0; m_rd = '0;
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] mb;
    for (int i = 0; i < 32; i++) mb[i] = mbusy[i];
    chk({tag, ".out_valid"},   64'(out_valid),   64'(m_valid));
    chk({tag, ".out_pc"},      64'(out_pc),      64'(m_pc));
    chk({tag, ".out_src1"},    64'(out_src1),    64'(m_src1));
    chk({tag, ".out_src2"},    64'(out_src2),    64'(m_src2));
    chk({tag, ".out_rd"},      64'(out_rd),      64'(m_rd));
    chk({tag, ".out_wen"},     64'(out_wen),     64'(m_wen));
    chk({tag, ".out_illegal"}, 64'(out_illegal), 64'(m_ill));
    chk({tag, ".out_inst"},    64'(out_inst),    64'(m_inst));
    chk({tag, ".busy"},        64'(dut.busy_q),  64'(mb));
  endtask

  task automatic set_in(input logic v, input logic [31:0] inst, input logic ordy,
                        input logic wbv, input logic [4:0] wbr, input logic fl);
    in_valid = v; in_inst = inst; out_ready = ordy;
    wb_valid = wbv; wb_rd = wbr; flush = fl;
  endtask

  // Called at a negedge with inputs applied; checks combinational outputs,
  // advances the model across one posedge and checks the registered outputs.
  task automatic step(input string tag);
    logic [3:0] f;
    logic [4:0] rs1, rs2, rd;
    bit hz, exp_rdy, fire, nwen;
    #1;
    f   = dec(in_inst[6:0]);
    rs1 = in_inst[19:15];
    rs2 = in_inst[24:20];
    rd  = in_inst[11:7];
    hz  = (f[3] && rs1 != 0 && mbusy[rs1]) || (f[2] && rs2 != 0 && mbusy[rs2])
       || (f[1] && rd != 0 && mbusy[rd]);
    exp_rdy = (!m_valid || out_ready) && !hz && !flush;
    chk({tag, ".ra"},       64'(ra),       64'(rs1));
    chk({tag, ".rb"},       64'(rb),       64'(rs2));
    chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
    last_ready = in_ready;
    fire = in_valid && exp_rdy;
    nwen = f[1] && rd != 0;
    @(posedge clk);
    if (wb_valid && wb_rd != 0) mbusy[wb_rd] = 1'b0;
    if (flush && m_valid && m_wen) mbusy[m_rd] = 1'b0;
    if (fire) begin
      m_valid = 1'b1; m_pc = in_pc; m_inst = in_inst;
      m_src1 = (rs1 == 0) ? 32'd0 : busA;
      m_src2 = (rs2 == 0) ? 32'd0 : busB;
      m_rd = rd; m_wen = nwen; m_ill = f[0];
      if (nwen) mbusy[rd] = 1'b1;
    end else if (m_valid && (flush || out_ready)) begin
      m_valid = 1'b0;
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    rstn = 1'b0;
    #1;
    model_clear();
    check_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  ra, rb;
    logic        wen, ill;
    logic [31:0] src1, src2;
  } vec_t;

  vec_t tbl [11];

  initial begin
    logic [6:0]  ops [12];
    logic [31:0] inst;

    tbl[0]  = '{32'h00500093, 5'd0,  5'd5,  1'b1, 1'b0, 32'h0,        32'h22222222};
    tbl[1]  = '{32'h00108133, 5'd1,  5'd1,  1'b1, 1'b0, 32'h11111111, 32'h22222222};
    tbl[2]  = '{32'h00000013, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0};
    tbl[3]  = '{32'hFFFFFFFF, 5'd31, 5'd31, 1'b0, 1'b1, 32'h11111111, 32'h22222222};
    tbl[4]  = '{32'h0021A023, 5'd3,  5'd2,  1'b0, 1'b0, 32'h11111111, 32'h22222222};
    tbl[5]  = '{32'h123453B7, 5'd8,  5'd3,  1'b1, 1'b0, 32'h11111111, 32'h22222222};
    tbl[6]  = '{32'h00208063, 5'd1,  5'd2,  1'b0, 1'b0, 32'h11111111, 32'h22222222};
    tbl[7]  = '{32'h00000073, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0};
    tbl[8]  = '{32'h000000EF, 5'd0,  5'd0,  1'b1, 1'b0, 32'h0,        32'h0};
    tbl[9]  = '{32'h00008067, 5'd1,  5'd0,  1'b0, 1'b0, 32'h11111111, 32'h0};
    tbl[10] = '{32'h00000037, 5'd0,  5'd0,  1'b0, 1'b0, 32'h0,        32'h0};

    rstn = 1'b0;
    in_pc = 32'h8000_0000; busA = 32'h11111111; busB = 32'h22222222;
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    @(negedge clk);

    // Decode table, each vector from a clean scoreboard.
    for (int i = 0; i < 11; i++) begin
      do_reset();
      in_pc = 32'h8000_0000 + 32'(i * 4);
      set_in(1'b1, tbl[i].inst, 1'b1, 1'b0, 5'd0, 1'b0);
      step("tbl");
      chk("tbl.ra",   64'(ra),          64'(tbl[i].ra));
      chk("tbl.rb",   64'(rb),          64'(tbl[i].rb));
      chk("tbl.vld",  64'(out_valid),   64'(1'b1));
      chk("tbl.wen",  64'(out_wen),     64'(tbl[i].wen));
      chk("tbl.ill",  64'(out_illegal), 64'(tbl[i].ill));
      chk("tbl.src1", 64'(out_src1),    64'(tbl[i].src1));
      chk("tbl.src2", 64'(out_src2),    64'(tbl[i].src2));
      $display("vec %0d inst=%h wen=%0b ill=%0b src1=%h src2=%h", i, tbl[i].inst,
               out_wen, out_illegal, out_src1, out_src2);
    end

    // addi x1 issues and marks x1 busy; add x2,x1,x1 waits until after writeback.
    do_reset();
    busA = 32'h1234;
    set_in(1'b1, 32'h00500093, 1'b0, 1'b0, 5'd0, 1'b0);
    step("addi");
    chk("addi.vld",  64'(out_valid),     64'(1'b1));
    chk("addi.rd",   64'(out_rd),        64'(5'd1));
    chk("addi.wen",  64'(out_wen),       64'(1'b1));
    chk("addi.src1", 64'(out_src1),      64'(32'd0));
    chk("addi.busy", 64'(dut.busy_q[1]), 64'(1'b1));
    set_in(1'b1, 32'h00108133, 1'b1, 1'b0, 5'd0, 1'b0);
    step("raw_wait");
    chk("raw.blocked", 64'(last_ready), 64'(1'b0));
    set_in(1'b1, 32'h00108133, 1'b1, 1'b1, 5'd1, 1'b0);
    step("raw_wb");
    chk("raw.wb_same", 64'(last_ready), 64'(1'b0));
    set_in(1'b1, 32'h00108133, 1'b1, 1'b0, 5'd0, 1'b0);
    step("raw_go");
    chk("raw.wb_next", 64'(last_ready), 64'(1'b1));
    chk("raw.inst",    64'(out_inst),   64'(32'h00108133));
    $display("raw sequence: add issued after writeback, out_rd=%0d", out_rd);

    // Backpressure: the held entry stays put, then is replaced with no bubble.
    do_reset();
    set_in(1'b1, 32'h00700193, 1'b1, 1'b0, 5'd0, 1'b0);
    step("bp_a");
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 32'h00100213, 1'b0, 1'b0, 5'd0, 1'b0);
      step("bp_hold");
      chk("bp.ready", 64'(last_ready), 64'(1'b0));
      chk("bp.inst",  64'(out_inst),   64'(32'h00700193));
    end
    set_in(1'b1, 32'h00100213, 1'b1, 1'b0, 5'd0, 1'b0);
    step("bp_go");
    chk("bp.go_ready", 64'(last_ready), 64'(1'b1));
    chk("bp.go_vld",   64'(out_valid),  64'(1'b1));
    chk("bp.go_inst",  64'(out_inst),   64'(32'h00100213));
    $display("backpressure sequence: out_inst=%h", out_inst);

    // Flush of a held x5 writer releases x5 and blocks the incoming instruction.
    do_reset();
    set_in(1'b1, 32'h00100293, 1'b1, 1'b0, 5'd0, 1'b0);
    step("fl_a");
    set_in(1'b1, 32'h00000013, 1'b0, 1'b0, 5'd0, 1'b1);
    step("flush");
    chk("flush.ready", 64'(last_ready),     64'(1'b0));
    chk("flush.vld",   64'(out_valid),      64'(1'b0));
    chk("flush.busy5", 64'(dut.busy_q[5]),  64'(1'b0));
    $display("flush sequence: out_valid=%0b busy5=%0b", out_valid, dut.busy_q[5]);

    // Asynchronous reset pulse between edges, then first fire on the next edge.
    set_in(1'b1, 32'h00100293, 1'b1, 1'b0, 5'd0, 1'b0);
    step("pulse_a");
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0);
    #2 rstn = 1'b0;
    #1;
    model_clear();
    check_outputs("pulse");
    #1 rstn = 1'b1;
    @(negedge clk);
    set_in(1'b1, 32'h00100293, 1'b1, 1'b0, 5'd0, 1'b0);
    step("pulse_fire");
    chk("pulse.fire", 64'(out_valid), 64'(1'b1));
    $display("reset pulse sequence: out_valid=%0b after first edge", out_valid);

    // Randomized traffic on a few registers to provoke hazards and collisions.
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h63, 7'h23, 7'h33, 7'h73, 7'h7F, 7'h00};
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      inst = $urandom;
      inst[6:0]   = ops[$urandom_range(0, 11)];
      inst[11:7]  = 5'($urandom_range(0, 3));
      inst[19:15] = 5'($urandom_range(0, 3));
      inst[24:20] = 5'($urandom_range(0, 3));
      in_pc = $urandom; busA = $urandom; busB = $urandom;
      set_in(1'($urandom_range(0, 3) != 0), inst, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 4)),
             1'($urandom_range(0, 19) == 0));
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
